// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor family.
package serial_addsub_pkg;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;
endpackage

// File: rtl/addsub_bit_cell.sv
// Combinational 1-bit full adder / full subtractor selected by mode.
module addsub_bit_cell
  import serial_addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic mode,
  output logic s,
  output logic co
);
  logic a_eff;

  // Borrow is the carry equation with the minuend inverted.
  assign a_eff = (mode == MODE_ADD) ? a : ~a;
  assign s     = a ^ b ^ c;
  assign co    = (a_eff & b) | (a_eff & c) | (b & c);
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first, one bit per clock through a single cell.
// Handshake: start is taken only while busy=0 (including the done cycle); done pulses one cycle with result valid.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             mode_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cell_s;
  logic             cell_co;
  logic [WIDTH:0]   res_ext;
  logic             last;

  addsub_bit_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c    (carry),
    .mode (mode_q),
    .s    (cell_s),
    .co   (cell_co)
  );

  assign res_ext = {cell_s, result};
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      mode_q <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            mode_q <= mode;
            carry  <= cin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          result <= res_ext[WIDTH:1];
          carry  <= cell_co;
          cnt    <= cnt + 1'b1;
          if (last) begin
            // On the last bit the shift registers hold the operand MSBs and cell_s is the result MSB.
            cout <= cell_co;
            if (mode_q == MODE_ADD)
              ovf <= (a_sh[0] == b_sh[0]) & (cell_s != a_sh[0]);
            else
              ovf <= (a_sh[0] != b_sh[0]) & (cell_s != a_sh[0]);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub at WIDTH=8 and WIDTH=1.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 1'b0, mode8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] result8;

  logic       start1 = 1'b0, mode1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] result1;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic       exp_c_q[$];
  logic       exp_v_q[$];

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .result(result1), .cout(cout1), .ovf(ovf1)
  );

  typedef struct {
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       cout;
    logic       ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic plus the MSB-sign overflow rule.
  function automatic void ref_op(input int w, input logic m, input logic [31:0] x,
                                 input logic [31:0] y, input logic c,
                                 output logic [31:0] r, output logic co, output logic ov);
    logic [32:0] full;
    logic [32:0] mask;
    mask = (33'h1 << w) - 33'h1;
    if (m) full = {1'b0, x} + {1'b0, y} + 33'(c);
    else   full = {1'b0, x} - {1'b0, y} - 33'(c);
    r  = 32'(full & mask);
    co = m ? full[w] : ({1'b0, x} < ({1'b0, y} + 33'(c)));
    if (m) ov = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
    else   ov = (x[w-1] != y[w-1]) && (r[w-1] != x[w-1]);
  endfunction

  task automatic run8(input logic m, input logic [7:0] x, input logic [7:0] y, input logic c,
                      output logic [7:0] r, output logic co, output logic ov,
                      output int busy_cnt, output int done_at);
    @(negedge clk);
    start8 = 1'b1; mode8 = m; a8 = x; b8 = y; cin8 = c;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom); cin8 = 1'($urandom);
    busy_cnt = 0; done_at = -1; r = '0; co = 1'b0; ov = 1'b0;
    for (int t = 0; t < 12; t++) begin
      if (busy8) busy_cnt++;
      if (done8) begin
        if (done_at < 0) begin
          done_at = t; r = result8; co = cout8; ov = ovf8;
        end else done_at = 99;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check8(input string nm, input logic m, input logic [7:0] x,
                        input logic [7:0] y, input logic c);
    logic [31:0] er;
    logic        ec, ev, co, ov;
    logic [7:0]  r;
    int          bc, da;
    ref_op(8, m, 32'(x), 32'(y), c, er, ec, ev);
    run8(m, x, y, c, r, co, ov, bc, da);
    chk({nm, " result"}, 32'(r), er);
    chk({nm, " cout"}, 32'(co), 32'(ec));
    chk({nm, " ovf"}, 32'(ov), 32'(ev));
    chk({nm, " done_at"}, 32'(da), 32'd8);
    chk({nm, " busy_cycles"}, 32'(bc), 32'd8);
  endtask

  initial begin
    vec_t vecs[7];
    vecs[0] = '{1'b0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy8", 32'(busy8), 0);
    chk("rst done8", 32'(done8), 0);
    chk("rst result8", 32'(result8), 0);
    chk("rst cout8", 32'(cout8), 0);
    chk("rst ovf8", 32'(ovf8), 0);
    chk("rst busy1", 32'(busy1), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      logic [7:0] r;
      logic       co, ov;
      int         bc, da;
      run8(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].cin, r, co, ov, bc, da);
      chk($sformatf("vec%0d result", i), 32'(r), 32'(vecs[i].res));
      chk($sformatf("vec%0d cout", i), 32'(co), 32'(vecs[i].cout));
      chk($sformatf("vec%0d ovf", i), 32'(ov), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d done_at", i), 32'(da), 32'd8);
      chk($sformatf("vec%0d busy_cycles", i), 32'(bc), 32'd8);
    end

    // Random operands against the reference
    for (int i = 0; i < 25; i++)
      check8($sformatf("rand%0d", i), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));

    // start held high with fresh operands every cycle: accepts every 9 edges
    begin
      int last_done;
      int n_done;
      last_done = -1; n_done = 0;
      for (int t = 0; t < 27; t++) begin
        logic [31:0] er;
        logic        ec, ev;
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        cin8 = 1'($urandom);
        @(posedge clk);
        if (t % 9 == 0) begin
          ref_op(8, mode8, 32'(a8), 32'(b8), cin8, er, ec, ev);
          exp_q.push_back(er[7:0]); exp_c_q.push_back(ec); exp_v_q.push_back(ev);
        end
        #1;
        chk($sformatf("b2b done t%0d", t), 32'(done8), 32'(t % 9 == 8));
        if (done8 && exp_q.size() > 0) begin
          n_done++;
          if (last_done >= 0) chk("b2b spacing", 32'(t - last_done), 32'd9);
          last_done = t;
          chk("b2b result", 32'(result8), 32'(exp_q.pop_front()));
          chk("b2b cout", 32'(cout8), 32'(exp_c_q.pop_front()));
          chk("b2b ovf", 32'(ovf8), 32'(exp_v_q.pop_front()));
        end
      end
      @(negedge clk);
      start8 = 1'b0;
      chk("b2b done count", 32'(n_done), 32'd3);
      repeat (10) @(posedge clk);
    end

    // start pulses during busy are ignored
    begin
      logic [31:0] er;
      logic        ec, ev;
      int          n_done, da;
      ref_op(8, 1'b0, 32'h3C, 32'h5A, 1'b1, er, ec, ev);
      @(negedge clk);
      start8 = 1'b1; mode8 = 1'b0; a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b1;
      @(posedge clk); #1;
      n_done = 0; da = -1;
      for (int t = 0; t < 16; t++) begin
        if (done8) begin n_done++; da = t; end
        if (t == 8) chk("busy-start result", 32'(result8), er);
        @(negedge clk);
        start8 = (t == 1 || t == 3 || t == 5);
        a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
        @(posedge clk); #1;
      end
      start8 = 1'b0;
      chk("busy-start done count", 32'(n_done), 32'd1);
      chk("busy-start done_at", 32'(da), 32'd8);
    end

    // Reset mid-operation at edge k+4
    begin
      int n_done;
      @(negedge clk);
      start8 = 1'b1; mode8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort busy", 32'(busy8), 0);
      chk("abort done", 32'(done8), 0);
      chk("abort result", 32'(result8), 0);
      chk("abort cout", 32'(cout8), 0);
      chk("abort ovf", 32'(ovf8), 0);
      @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      for (int t = 0; t < 14; t++) begin
        @(posedge clk); #1;
        if (done8 || busy8) n_done++;
      end
      chk("abort no done", 32'(n_done), 0);
    end

    // WIDTH=1 truth table
    for (int v = 0; v < 16; v++) begin
      logic [31:0] er;
      logic        ec, ev, m, x, y, c;
      int          da, bc;
      logic        r, co;
      {m, x, y, c} = 4'(v);
      ref_op(1, m, 32'(x), 32'(y), c, er, ec, ev);
      @(negedge clk);
      start1 = 1'b1; mode1 = m; a1 = x; b1 = y; cin1 = c;
      @(posedge clk); #1;
      start1 = 1'b0; a1 = ~x; b1 = ~y;
      da = -1; bc = 0; r = 1'b0; co = 1'b0;
      for (int t = 0; t < 4; t++) begin
        if (busy1) bc++;
        if (done1) begin
          if (da < 0) begin da = t; r = result1[0]; co = cout1; end else da = 99;
        end
        @(posedge clk); #1;
      end
      chk($sformatf("w1 v%0d result", v), 32'(r), er);
      chk($sformatf("w1 v%0d cout", v), 32'(co), 32'(ec));
      chk($sformatf("w1 v%0d done_at", v), 32'(da), 32'd1);
      chk($sformatf("w1 v%0d busy", v), 32'(bc), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor, the sequential successor to our 1-bit mux-based full-subtractor cell.
- Accepts two WIDTH-bit operands and a mode, then processes one bit per clock, LSB first, through a single full-add/full-subtract cell.
- Returns the result, the final carry/borrow and a signed-overflow flag, with a start/busy/done handshake.
- Sits in the arithmetic datapath wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits (≥1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- mode  input  1  0 = subtract (a−b), 1 = add (a+b); latched at accept
- a  input  WIDTH  minuend / addend; latched at accept
- b  input  WIDTH  subtrahend / addend; latched at accept
- cin  input  1  initial borrow-in (sub) or carry-in (add); latched at accept
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when the result is valid
- result  output  WIDTH  difference or sum
- cout  output  1  final borrow-out (sub) or carry-out (add)
- ovf  output  1  two's-complement overflow

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - busy, done, result, cout, ovf all go to 0.
  - Internal shift registers, bit counter and carry register are cleared.
  - Reset overrides start and aborts any operation in flight; no done is produced for an aborted operation.
- FSM has two states, IDLE and RUN.
- IDLE:
  - Accept condition: start=1 at edge k.
  - On accept: latch a, b, mode, cin; set the carry register to cin; set counter=0; set busy=1; go to RUN.
  - If start=0, stay in IDLE. result, cout and ovf hold their last values.
- RUN, at edges k+1 … k+WIDTH:
  - Feed bit[counter] of a, b and the carry register into the cell.
  - Shift the cell sum/diff into result, LSB first.
  - Update the carry register with the cell carry/borrow.
  - Increment the counter.
- Cell equations:
  - sub: diff = a^b^c; borrow = (~a&b) | (~a&c) | (b&c).
  - add: sum = a^b^c; carry = (a&b) | (a&c) | (b&c).
- Completion at edge k+WIDTH (the last bit):
  - result holds the full value; cout = final carry/borrow.
  - ovf: sub = (a[W−1]≠b[W−1]) & (result[W−1]≠a[W−1]); add = (a[W−1]=b[W−1]) & (result[W−1]≠a[W−1]).
  - done=1 for exactly one cycle; busy=0; state returns to IDLE.
- Latency: done is high in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- start while busy=1 is ignored; it is not queued.
- start asserted during the done cycle is accepted, giving back-to-back operation.
- Input changes after accept do not affect the operation in progress.
- result is not guaranteed meaningful while busy=1; it is valid from the done cycle until the next accept.
- WIDTH=1 degenerates to a registered single-bit cell with 2-cycle latency.
- The counter is $clog2(WIDTH+1) bits wide and never wraps within an operation.

Decomposition:
- Shared package: state encoding (ST_IDLE, ST_RUN) and mode constants (MODE_SUB=0, MODE_ADD=1).
- One sub-module, addsub_bit_cell: purely combinational 1-bit full adder/subtractor with inputs a, b, c, mode and outputs s, co.
  - It is the generalisation of the existing full-subtractor cell and is reused by future parallel variants.

Test Plan:
- WIDTH=8, sub, a=0x05, b=0x03, cin=0 → result=0x02, cout=0, ovf=0; done exactly 9 cycles after the start edge; busy high for 8 cycles.
- WIDTH=8, sub, a=0x03, b=0x05, cin=0 → result=0xFE, cout=1, ovf=0. Repeat with a=0x80, b=0x01 → result=0x7F, cout=0, ovf=1.
- WIDTH=8, add, a=0xFF, b=0x01, cin=0 → result=0x00, cout=1, ovf=0. Repeat with a=0x7F, b=0x01 → result=0x80, cout=0, ovf=1.
- Handshake:
  - start held high continuously with new operands each cycle → only operands at the accept edges are used.
  - Operations run back-to-back with done pulses 9 cycles apart.
  - start pulses during busy produce no extra done.
- Assert rst at edge k+4 of an operation → next cycle busy=0, done=0, result=0, cout=0, ovf=0; no done afterwards until a new start.
- WIDTH=1, all 16 combinations of {mode, a, b, cin} → result/cout match the full-subtractor/full-adder truth table; done 2 cycles after start.
